// File: rtl/y86_seq_ctrl_if.sv
// Control/status bundle between the top-level wrapper and the SEQ sequencer.
interface y86_seq_ctrl_if #(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 32
);
  logic             start;
  logic             abort;
  logic             step_mode;
  logic             step_req;
  logic             hlt;
  logic             instr_valid;
  logic             imem_error;
  logic             dmem_error;
  logic             mem_ready;
  logic [PC_W-1:0]  updated_pc;
  logic [PC_W-1:0]  pc;
  logic [5:0]       stage_en;
  logic             wb_en;
  logic [1:0]       stat;
  logic             running;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  // Wrapper side: issues commands and stage status, observes sequencer state.
  modport master (
    output start, abort, step_mode, step_req, hlt, instr_valid, imem_error,
           dmem_error, mem_ready, updated_pc,
    input  pc, stage_en, wb_en, stat, running, done, cycle_cnt, instr_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, abort, step_mode, step_req, hlt, instr_valid, imem_error,
           dmem_error, mem_ready, updated_pc,
    output pc, stage_en, wb_en, stat, running, done, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle sequencer for the SEQ Y86-64 core: owns PC and status, steps one
// stage per cycle, adds memory timeout, single-step, sticky faults and counters.
module y86_seq_ctrl #(
  parameter int unsigned     PC_W        = 64,
  parameter int unsigned     CNT_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int unsigned     MEM_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  y86_seq_ctrl_if.slave bus
);
  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
    S_WRITEBACK, S_PC_UPD, S_PAUSE, S_STOP
  } state_t;

  state_t           state, state_nx;
  logic [PC_W-1:0]  pc_q, pc_nx;
  logic [1:0]       stat_q, stat_nx;
  logic [TO_W-1:0]  to_cnt, to_nx;
  logic [CNT_W-1:0] cyc_q, cyc_nx;
  logic [CNT_W-1:0] ins_q, ins_nx;
  logic [5:0]       stage_q, stage_nx;
  logic             wb_q, wb_nx;
  logic             run_q, run_nx;
  logic             done_q, done_nx;
  logic             ins_inc;

  // State, architectural state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      to_cnt  <= '0;
      cyc_q   <= '0;
      ins_q   <= '0;
      stage_q <= '0;
      wb_q    <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      pc_q    <= pc_nx;
      stat_q  <= stat_nx;
      to_cnt  <= to_nx;
      cyc_q   <= cyc_nx;
      ins_q   <= ins_nx;
      stage_q <= stage_nx;
      wb_q    <= wb_nx;
      run_q   <= run_nx;
      done_q  <= done_nx;
    end
  end

  // Next state, architectural updates, and output values for the next state.
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    stat_nx  = stat_q;
    to_nx    = to_cnt;
    ins_inc  = 1'b0;
    stage_nx = '0;
    wb_nx    = 1'b0;
    run_nx   = 1'b0;
    done_nx  = 1'b0;

    case (state)
      S_IDLE: if (bus.start) state_nx = S_FETCH;
      S_FETCH: begin
        if (bus.imem_error) begin
          stat_nx  = STAT_ADR;
          state_nx = S_STOP;
        end else if (!bus.instr_valid) begin
          stat_nx  = STAT_INS;
          state_nx = S_STOP;
        end else if (bus.hlt) begin
          stat_nx  = STAT_HLT;
          state_nx = S_STOP;
        end else begin
          state_nx = S_DECODE;
        end
      end
      S_DECODE: state_nx = S_EXECUTE;
      S_EXECUTE: begin
        state_nx = S_MEMORY;
        to_nx    = '0;
      end
      S_MEMORY: begin
        if (bus.dmem_error) begin
          stat_nx  = STAT_ADR;
          state_nx = S_STOP;
        end else if (bus.mem_ready) begin
          state_nx = S_WRITEBACK;
        end else if (to_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
          stat_nx  = STAT_ADR;
          state_nx = S_STOP;
        end else begin
          to_nx = to_cnt + TO_W'(1);
        end
      end
      S_WRITEBACK: state_nx = S_PC_UPD;
      S_PC_UPD: begin
        pc_nx    = bus.updated_pc;
        ins_inc  = 1'b1;
        state_nx = bus.step_mode ? S_PAUSE : S_FETCH;
      end
      S_PAUSE: if (bus.step_req || !bus.step_mode) state_nx = S_FETCH;
      S_STOP: state_nx = S_STOP;
      default: state_nx = S_IDLE;
    endcase

    // Abort wins over everything, including a pending PC/instruction update.
    if (bus.abort) begin
      state_nx = S_IDLE;
      pc_nx    = pc_q;
      stat_nx  = stat_q;
      ins_inc  = 1'b0;
    end

    case (state_nx)
      S_FETCH:     stage_nx = 6'b000001;
      S_DECODE:    stage_nx = 6'b000010;
      S_EXECUTE:   stage_nx = 6'b000100;
      S_MEMORY:    stage_nx = 6'b001000;
      S_WRITEBACK: stage_nx = 6'b010000;
      S_PC_UPD:    stage_nx = 6'b100000;
      default:     stage_nx = 6'b000000;
    endcase
    wb_nx   = (state_nx == S_WRITEBACK);
    run_nx  = (state_nx != S_IDLE) && (state_nx != S_STOP);
    done_nx = (state_nx == S_STOP);

    cyc_nx = (run_q && (cyc_q != '1)) ? cyc_q + CNT_W'(1) : cyc_q;
    ins_nx = (ins_inc && (ins_q != '1)) ? ins_q + CNT_W'(1) : ins_q;
  end

  assign bus.pc        = pc_q;
  assign bus.stat      = stat_q;
  assign bus.stage_en  = stage_q;
  assign bus.wb_en     = wb_q;
  assign bus.running   = run_q;
  assign bus.done      = done_q;
  assign bus.cycle_cnt = cyc_q;
  assign bus.instr_cnt = ins_q;
endmodule

// File: doc/y86_seq_ctrl.md
# y86_seq_ctrl

Parametrised multi-cycle sequencer for the SEQ Y86-64 core. It owns the architectural PC and the processor status code, and steps the existing fetch/decode/execute/memory/writeback/PC-update datapath one stage per cycle. It adds several capabilities the free-running clock-driven core lacks: a memory-ready handshake with timeout, single-step debug mode, sticky fault status, and cycle and retired-instruction counters. It sits between the top-level wrapper and the stage modules, replacing the ad-hoc PC/stat logic.

## Interface
- PC_W, 64, width of PC and updated_pc
- CNT_W, 32, width of cycle_cnt and instr_cnt
- RESET_PC, 0, PC value loaded on reset
- MEM_TIMEOUT, 16, consecutive MEMORY cycles with mem_ready low before an ADR fault (≥1)
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin execution
- abort  in  1  synchronous return to IDLE from any state; PC and counters held
- step_mode  in  1  1 = pause after every retired instruction
- step_req  in  1  releases one instruction while in PAUSE
- hlt, instr_valid, imem_error  in  1 each  fetch status, sampled in FETCH
- dmem_error, mem_ready  in  1 each  memory status, sampled in MEMORY
- updated_pc  in  PC_W  next PC from pc_update, sampled in PC_UPD
- pc  out  PC_W  architectural PC driven to fetch
- stage_en  out  6  one-hot: [0]FETCH [1]DECODE [2]EXECUTE [3]MEMORY [4]WRITEBACK [5]PC_UPD
- wb_en  out  1  register-file write permission
- stat  out  2  0 AOK, 1 HLT, 2 ADR, 3 INS
- running, done  out  1 each  executing / stopped on HLT or fault
- cycle_cnt, instr_cnt  out  CNT_W each  saturating counters

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PC_UPD, PAUSE, STOP.
- IDLE: start → FETCH. stat is not cleared on start: after STOP, only reset clears stat.
- FETCH samples status in priority order imem_error → ADR; else !instr_valid → INS; else hlt → HLT. Any of these → STOP with PC unchanged. Otherwise → DECODE.
- DECODE → EXECUTE → MEMORY unconditionally.
- MEMORY:
  - dmem_error → stat=ADR, STOP. WRITEBACK is skipped and wb_en is never asserted.
  - mem_ready=1 → WRITEBACK.
  - mem_ready=0 → remain in MEMORY and increment the timeout count. When the count reaches MEM_TIMEOUT → ADR, STOP.
  - dmem_error has priority over mem_ready.
- WRITEBACK: wb_en=1 for this cycle only → PC_UPD.
- PC_UPD:
  - pc ← updated_pc.
  - instr_cnt += 1 (saturating).
  - Next state: step_mode ? PAUSE : FETCH.
- PAUSE: step_req=1 → FETCH. step_mode deasserted while in PAUSE → FETCH.
- STOP: done=1. Only reset or abort leaves STOP. abort → IDLE with stat held.
- abort has priority over every transition. Applied in MEMORY or WRITEBACK, it suppresses the pending PC update.
- cycle_cnt increments every cycle running=1.
- Both counters saturate at all-ones; they never wrap.
- Out-of-range PC arithmetic belongs to pc_update; this block loads updated_pc verbatim.

## Timing
- Reset (asynchronous assert, synchronous deassert handled externally):
  - state=IDLE, pc=RESET_PC, stage_en=0, wb_en=0, stat=AOK, running=0, done=0, counters=0.
- All outputs are registered.
- running=1 in every state except IDLE and STOP.
- stage_en reflects the current state, one bit per stage state; it is 0 in IDLE, PAUSE and STOP.
- With mem_ready tied high, one instruction is 6 cycles (FETCH..PC_UPD). The new pc is visible in the cycle after PC_UPD, concurrently with the next FETCH.
- Each mem_ready-low cycle adds one cycle. The timeout count is cleared on entry to MEMORY.
- start asserted outside IDLE is ignored. step_req outside PAUSE is ignored.
- HLT at FETCH: done rises on the cycle after FETCH; stage_en[1] never asserts for that instruction.

## Test plan
- Reset with RESET_PC=0x100 → pc=0x100, stat=0, all counters 0, stage_en=0. Pulse start, 3 valid instructions (updated_pc = pc+10), then hlt → pc=0x11E, stat=1, instr_cnt=3, cycle_cnt=19, done=1.
- mem_ready low 5 cycles on instruction 1, MEM_TIMEOUT=16 → instruction takes 11 cycles, no fault. Hold mem_ready low 16 cycles → stat=2, wb_en never high, pc unchanged.
- instr_valid=0 on the second fetch → stat=3, pc = first updated_pc, instr_cnt=1. Same cycle with imem_error=1 → stat=2 (priority check).
- dmem_error in MEMORY → stat=2, no wb_en pulse, STOP on the next cycle.
- step_mode=1 → PAUSE after each PC_UPD. Two step_req pulses → exactly 2 more instructions retire. Clearing step_mode in PAUSE → free run resumes.
- abort mid-MEMORY → IDLE next cycle, pc unchanged; a following start restarts at the held pc. rst_n low mid-EXECUTE → immediate reset values. CNT_W=4 run of 20 cycles → cycle_cnt=15.
